timer_bank: RTL
===============

Name: timer_bank

Overview:
- Parametrised bank of CH independent down-count timers. Generalises the team's one-second counter and long-press detector into one block.
- Each channel runs in one of three modes: one-shot, periodic (auto-reload tick generator) or hold (long-press style).
- Sits between the debounced button / control FSM logic and the game/display logic. Provides expiry levels, one-cycle tick pulses and a muxed count readout for seven-segment display.

Parameters:
- CH, 4, number of timer channels (1..16)
- WIDTH, 32, counter width in bits
- SELW, 2, width of cnt_sel; must be ≥ clog2(CH), minimum 1

Ports:
- clk  in  1  system clock (100 MHz)
- rst  in  1  reset, asynchronous, active-high
- start  in  CH  per-channel load/restart strobe, sampled each posedge
- hold  in  CH  per-channel level: pause in one-shot/periodic modes; press level in hold mode
- mode  in  2*CH  channel i at [2i+1:2i]. Encoding: 00 one-shot, 01 periodic, 10 hold, 11 treated as one-shot
- load_val  in  WIDTH*CH  channel i reload value L at [i*WIDTH +: WIDTH]
- cnt_sel  in  SELW  channel selected for readout
- cnt_rd  out  WIDTH  combinational: count of channel cnt_sel; 0 if cnt_sel ≥ CH
- tick  out  CH  registered one-cycle pulse per expiry event
- expired  out  CH  registered level: channel finished
- busy  out  CH  registered: channel in RUN

Behaviour:
- Clock and reset: one clock. Reset is asynchronous, active-high; all state is cleared immediately on rst=1, independent of clk.
- Reset values per channel: state IDLE, cnt=0, mode_q=00, tick=0, expired=0, busy=0.
- Per-channel FSM states: IDLE, RUN, DONE. busy=1 iff RUN. expired=1 iff DONE.
- mode_q latching: mode_q latches mode[i] on any edge where the channel is IDLE, or where start[i]=1. Mode changes while in RUN or DONE are ignored until then.
- Expiry event: posedge where state=RUN, cnt=0 and the channel is counting (see below).
  - On that edge: tick<=1 for exactly one cycle. Otherwise tick<=0 every edge.
- One-shot / periodic (mode_q 00/01/11):
  - start=1 in any state: cnt<=L (current load_val), state RUN, expired cleared. start has priority over a coincident expiry; no tick on that edge.
  - RUN, hold=0, cnt>0: cnt<=cnt-1.
  - RUN, hold=1: cnt and state frozen. A pending expiry is deferred.
  - Expiry in one-shot: state DONE, cnt stays 0. DONE persists until the next start.
  - Expiry in periodic: cnt<=L (sampled at this edge), state stays RUN.
  - Timing: start sampled at edge E0 gives tick high in the cycle after edge E0+L+1 (no pause), so the period is L+1 cycles. L=99_999_999 gives a 1 s tick.
  - L=0 in periodic mode: tick high every cycle while running.
  - IDLE with start=0: cnt holds its value.
- Hold mode (mode_q 10):
  - start is ignored.
  - hold=0 in any state: cnt<=L, state IDLE, expired cleared.
  - hold=1 from IDLE: state RUN, cnt<=cnt-1 (or stays 0 if cnt=0).
  - hold=1 in RUN, cnt>0: decrement. Expiry at cnt=0 → DONE, single tick.
  - hold=1 in DONE: stay DONE, no further ticks.
  - Timing: hold must be sampled high on L+1 consecutive edges before the tick. Any low sample restarts from L.
- Channels are fully independent. Simultaneous events on different channels never interact.
- Arithmetic: unsigned; no wrap below 0. load_val is sampled only at load edges, so mid-run changes affect only the next reload.
- Reset mid-run: immediate return to reset values. A tick that was high drops without completing its cycle.

Test Plan:
- Reset and one-shot: CH=4, WIDTH=8, rst pulse, then ch0 mode=00, L=5, start pulse at E0 → busy0=1, tick0 high only in the cycle after E0+6, expired0=1 thereafter, cnt_rd(sel 0)=0, other channels idle.
- Periodic and reload: ch1 mode=01, L=3, start → tick1 every 4 cycles for 5 periods. Change L to 1 mid-period → the following period is 2 cycles.
- Pause and simultaneous start: ch2 one-shot L=4 with hold=1 for 3 cycles mid-run → tick delayed by exactly 3 cycles. Start asserted on the expiry edge → no tick, cnt=4, busy stays 1.
- Hold (long-press) mode: ch3 mode=10, L=6. Hold high for 5 edges then low → no tick, cnt back to 6. Hold high for 10 edges → exactly one tick on the 7th edge, expired3=1 until hold drops.
- Asynchronous reset mid-operation: all channels running, rst asserted between clock edges → tick, expired and busy go 0 and cnt_rd=0 before the next edge. cnt_sel=5 with CH=4 → cnt_rd=0.
- Edge values: L=0 periodic → tick constantly 1. Mode=11 → behaves as one-shot. Mode change while RUN → ignored until the next start.

Source files
------------

// File: rtl/timer_bank.sv
// -----------------------------------------------------------------------------
// timer_bank
//   Bank of CH independent down-count timers. Each channel runs as a one-shot
//   timer, a periodic auto-reload tick generator, or a long-press (hold)
//   detector. It provides per-channel expiry levels, one-cycle tick pulses and
//   a muxed count readout for the seven-segment display.
//
// Parameters
//   CH     number of timer channels (1..16)
//   WIDTH  counter width in bits
//   SELW   width of cnt_sel; at least clog2(CH), minimum 1
//
// Ports
//   clk       in   system clock
//   rst       in   asynchronous active-high reset
//   start     in   [CH]        per-channel load/restart strobe
//   hold      in   [CH]        pause level (one-shot/periodic), press level (hold)
//   mode      in   [2*CH]      channel i at [2i+1:2i]: 00 one-shot, 01 periodic,
//                              10 hold, 11 one-shot
//   load_val  in   [WIDTH*CH]  channel i reload value at [i*WIDTH +: WIDTH]
//   cnt_sel   in   [SELW]      channel shown on cnt_rd
//   cnt_rd    out  [WIDTH]     combinational count of channel cnt_sel, 0 if out of range
//   tick      out  [CH]        registered one-cycle pulse per expiry event
//   expired   out  [CH]        registered level: channel finished (DONE)
//   busy      out  [CH]        registered level: channel running (RUN)
// -----------------------------------------------------------------------------
module timer_bank #(
    parameter int CH    = 4,
    parameter int WIDTH = 32,
    parameter int SELW  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CH-1:0]       start,
    input  logic [CH-1:0]       hold,
    input  logic [2*CH-1:0]     mode,
    input  logic [WIDTH*CH-1:0] load_val,
    input  logic [SELW-1:0]     cnt_sel,
    output logic [WIDTH-1:0]    cnt_rd,
    output logic [CH-1:0]       tick,
    output logic [CH-1:0]       expired,
    output logic [CH-1:0]       busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    localparam logic [1:0] MODE_PERIODIC = 2'b01;
    localparam logic [1:0] MODE_HOLD     = 2'b10;

    logic [WIDTH-1:0] w_cnt [CH];

    for (genvar i = 0; i < CH; i++) begin : g_ch
        state_t           r_state;
        state_t           w_state_nxt;
        logic [WIDTH-1:0] r_cnt;
        logic [WIDTH-1:0] w_cnt_nxt;
        logic [1:0]       r_mode_q;
        logic [1:0]       w_mode_eff;
        logic             r_tick;
        logic             w_tick_nxt;
        logic             w_latch;
        logic [WIDTH-1:0] w_load;

        assign w_load = load_val[i*WIDTH +: WIDTH];

        // The mode register follows the input while idle or on a start edge,
        // and that freshly latched mode already governs the same edge.
        assign w_latch    = (r_state == S_IDLE) || start[i];
        assign w_mode_eff = w_latch ? mode[2*i +: 2] : r_mode_q;

        always_comb begin
            // NOTE: every output of this block gets a default first, so no
            // path through the branches below can leave a latch behind.
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            w_tick_nxt  = 1'b0;

            if (w_mode_eff == MODE_HOLD) begin
                // Long-press: any low sample re-arms from L; start is ignored.
                if (!hold[i]) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = w_load;
                end else begin
                    case (r_state)
                        S_IDLE: begin
                            w_state_nxt = S_RUN;
                            if (r_cnt != '0) w_cnt_nxt = r_cnt - WIDTH'(1);
                        end
                        S_RUN: begin
                            if (r_cnt != '0) begin
                                w_cnt_nxt = r_cnt - WIDTH'(1);
                            end else begin
                                w_state_nxt = S_DONE;
                                w_tick_nxt  = 1'b1;
                            end
                        end
                        default: w_state_nxt = r_state;
                    endcase
                end
            end else if (start[i]) begin
                // A restart wins over a coincident expiry, so no tick here.
                w_state_nxt = S_RUN;
                w_cnt_nxt   = w_load;
            end else if (r_state == S_RUN && !hold[i]) begin
                // hold=1 freezes the channel, deferring a pending expiry.
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - WIDTH'(1);
                end else begin
                    w_tick_nxt = 1'b1;
                    if (w_mode_eff == MODE_PERIODIC) begin
                        w_cnt_nxt = w_load;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_state  <= S_IDLE;
                r_cnt    <= '0;
                r_mode_q <= 2'b00;
                r_tick   <= 1'b0;
            end else begin
                // NOTE: state is updated with non-blocking assignments so all
                // registers sample the pre-edge values, like real flops.
                r_state  <= w_state_nxt;
                r_cnt    <= w_cnt_nxt;
                r_mode_q <= w_mode_eff;
                r_tick   <= w_tick_nxt;
            end
        end

        assign w_cnt[i]   = r_cnt;
        assign tick[i]    = r_tick;
        assign expired[i] = (r_state == S_DONE);
        assign busy[i]    = (r_state == S_RUN);
    end

    // Readout mux; selections at or above CH match no channel and read 0.
    always_comb begin
        cnt_rd = '0;
        for (int k = 0; k < CH; k++) begin
            if (cnt_sel == SELW'(k)) cnt_rd = w_cnt[k];
        end
    end

endmodule
